conv3x3_window_ctrl: RTL
========================

// Module: conv3x3_window_ctrl
// PURPOSE
//  Streaming sequencer for the 3x3 convolution MAC datapath. Accepts a raster pixel stream,
//  keeps two line buffers plus a 3x3 window, and holds the 9 kernel coefficients.
//  Drives the external combinational MAC: window on w1..w9, kernel on k1..k9.
//  Registers the MAC sum into a valid/ready output stream (valid-only convolution, no padding).
// PARAMETERS
//  IMG_W   64  pixels per row (>=3)
//  IMG_H   64  rows per frame (>=3)
//  PIX_W    8  pixel/coefficient width
//  SUM_W   20  width of mac_sum from MAC (2*PIX_W+4 holds 9 full-scale products)
//  OUT_W    8  output pixel width
//  SHIFT    0  right shift applied to mac_sum before width reduction
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  start      in   1          1-cycle pulse; begins a frame (honoured only in IDLE)
//  k_we       in   1          kernel write strobe (honoured only in IDLE)
//  k_idx      in   4          tap index 0..8 (0=w1 top-left, 8=w9 bottom-right); >8 ignored
//  k_data     in   PIX_W      coefficient value
//  in_valid   in   1          pixel valid
//  in_ready   out  1          pixel accepted when in_valid&in_ready
//  in_data    in   PIX_W      pixel, raster order
//  win        out  9*PIX_W    window to MAC, tap n at [n*PIX_W +: PIX_W]
//  kern       out  9*PIX_W    coefficients to MAC, same packing
//  mac_sum    in   SUM_W      combinational sum returned by MAC for current win/kern
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream ready
//  out_data   out  OUT_W      convolution result
//  busy       out  1          high outside IDLE
//  done       out  1          1-cycle pulse when last result of frame is accepted
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, busy, done = 0; out_data, win, kern, counters,
//   line buffers = 0. Asynchronous; reset mid-frame discards the frame with no done.
//  FSM: IDLE -start-> STREAM -last pixel accepted-> FLUSH -out accepted or !out_valid-> IDLE.
//   done pulses on the FLUSH->IDLE transition (one cycle).
//  in_ready = (state==STREAM) && (!out_valid || out_ready). No pixel is accepted while a result stalls.
//  Counters col 0..IMG_W-1, row 0..IMG_H-1 advance per accepted pixel; col wraps to 0 and row increments.
//  On accept: window shifts left one column; new right column = {lb1[col], lb0[col], in_data}
//   (top..bottom); line buffers update (lb1[col]<=lb0[col], lb0[col]<=in_data).
//  Result: if accepted pixel has row>=2 && col>=2, next cycle out_valid=1,
//   out_data=reduce(mac_sum>>SHIFT) computed on the post-shift window. Latency 1 cycle.
//   Window contents spanning a row wrap (col<2) are never emitted.
//  out_valid/out_data hold until out_ready; accept and new result in same cycle allowed.
//  Results per frame: (IMG_W-2)*(IMG_H-2).
//  Arithmetic: mac_sum is unsigned; shift is logical.
//  start while busy, k_we while busy: ignored. Kernel regs persist across frames.
// CONFIGURATION
//  CONV_SAT_EN defined: reduce() saturates — values > 2^OUT_W-1 give 2^OUT_W-1.
//  CONV_SAT_EN undefined: reduce() truncates to low OUT_W bits.
// STRUCTURE
//  Package conv_pkg: KERNEL_TAPS=9, state enum {IDLE,STREAM,FLUSH}, tap index constants.
//  Sub-module conv_line_buffer: IMG_W x PIX_W dual-row store, one read/write per column,
//   instantiated once holding both rows.
// TESTING
//  5x5 frame, pixel=row*5+col, all-ones kernel, SHIFT=0 -> 9 outputs: 54,63,72,99,108,117,144,153,162; done after 9th.
//  Same frame, kernel k_idx4=1 else 0 -> outputs 6,7,8,11,12,13,16,17,18.
//  All pixels 255, all-ones kernel -> with CONV_SAT_EN 255; without 247 (2295 mod 256).
//  Hold out_ready low 3 cycles mid-frame -> in_ready low, out_data stable, no result lost or duplicated.
//  k_we idx4=9 and start during STREAM -> kernel and frame unaffected; k_idx=12 in IDLE -> no change.
//  Assert rst_n low mid-frame -> all outputs 0 immediately; new start gives the correct first frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window sequencer:
// kernel tap count, FSM state encoding and window tap positions.
package conv_pkg;

  localparam int KERNEL_TAPS = 9;

  // Tap positions in the window: row-major, 0 = top-left (w1), 8 = bottom-right (w9).
  localparam int TAP_W1 = 0;
  localparam int TAP_W2 = 1;
  localparam int TAP_W3 = 2;
  localparam int TAP_W4 = 3;
  localparam int TAP_W5 = 4;
  localparam int TAP_W6 = 5;
  localparam int TAP_W7 = 6;
  localparam int TAP_W8 = 7;
  localparam int TAP_W9 = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Window tap index for a (row, column) position inside the 3x3 window.
  function automatic int tap_idx(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line store for the convolution window. Row 0 holds the previous
// image row, row 1 the one before it. One column is read and written per
// accepted pixel: the old row-0 value moves into row 1, the new pixel into row 0.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int PIX_W = 8,
  parameter int COL_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COL_W-1:0] col_i,
  input  logic             we_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] row0_o,
  output logic [PIX_W-1:0] row1_o
);

  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];

  // Read port is combinational so the window sees the column contents before this pixel's update.
  assign row0_o = lb0_q[col_i];
  assign row1_o = lb1_q[col_i];

  // Column update on accept: row 0 ages into row 1, new pixel lands in row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (we_i) begin
      lb1_q[col_i] <= lb0_q[col_i];
      lb0_q[col_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Streaming sequencer for an external combinational 3x3 MAC.
// Builds the sliding window from a raster pixel stream, holds the kernel,
// and presents the MAC result as a valid/ready output stream.
// Optional feature: define CONV_SAT_EN to saturate the result instead of truncating.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state, out_valid and out_ready, never on
// in_valid. out_valid, once high, stays high with out_data unchanged until the
// cycle in which out_ready is high.
module conv3x3_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  parameter int SUM_W = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         k_we,
  input  logic [3:0]                   k_idx,
  input  logic [PIX_W-1:0]             k_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIX_W-1:0]             in_data,
  output logic [KERNEL_TAPS*PIX_W-1:0] win,
  output logic [KERNEL_TAPS*PIX_W-1:0] kern,
  input  logic [SUM_W-1:0]             mac_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic                         busy,
  output logic                         done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] win_q  [KERNEL_TAPS];
  logic [PIX_W-1:0] win_d  [KERNEL_TAPS];
  logic [PIX_W-1:0] kern_q [KERNEL_TAPS];
  logic [PIX_W-1:0] kern_d [KERNEL_TAPS];
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             emit;
  logic [PIX_W-1:0] lb_row0;
  logic [PIX_W-1:0] lb_row1;
  logic [OUT_W-1:0] reduced;

  assign in_ready = (state_q == STREAM) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  // Only windows lying fully inside one row band produce a result.
  assign emit     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W),
    .COL_W (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .col_i   (col_q),
    .we_i    (accept),
    .wdata_i (in_data),
    .row0_o  (lb_row0),
    .row1_o  (lb_row1)
  );

  // Frame sequencing: idle until start, stream pixels, then drain the final result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && col_last && row_last) state_d = FLUSH;
      FLUSH:   if (!out_valid_q || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel; cleared at frame start.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == IDLE && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Window slides left one column per accepted pixel; right column comes from the line store.
  always_comb begin
    for (int i = 0; i < KERNEL_TAPS; i++) win_d[i] = win_q[i];
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[tap_idx(r, 0)] = win_q[tap_idx(r, 1)];
        win_d[tap_idx(r, 1)] = win_q[tap_idx(r, 2)];
      end
      win_d[TAP_W3] = lb_row1;
      win_d[TAP_W6] = lb_row0;
      win_d[TAP_W9] = in_data;
    end
  end

  // Coefficients are writable only while idle; out-of-range tap indices are dropped.
  always_comb begin
    for (int i = 0; i < KERNEL_TAPS; i++) kern_d[i] = kern_q[i];
    if (state_q == IDLE && k_we && k_idx < 4'(KERNEL_TAPS)) begin
      kern_d[k_idx] = k_data;
    end
  end

  // Result valid appears the cycle after an emitting pixel and holds until taken.
  always_comb begin
    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (emit)      out_valid_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        win_q[i]  <= '0;
        kern_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        win_q[i]  <= win_d[i];
        kern_q[i] <= kern_d[i];
      end
    end
  end

  // The window only moves on accept, so mac_sum stays stable while a result is stalled.
`ifdef CONV_SAT_EN
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((64'd1 << OUT_W) - 64'd1);
  logic [SUM_W-1:0] shifted;
  assign shifted = mac_sum >> SHIFT;
  assign reduced = (shifted > SAT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
`else
  assign reduced = OUT_W'(mac_sum >> SHIFT);
`endif

  for (genvar n = 0; n < KERNEL_TAPS; n++) begin : g_pack
    assign win[n*PIX_W +: PIX_W]  = win_q[n];
    assign kern[n*PIX_W +: PIX_W] = kern_q[n];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? reduced : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FLUSH) && (!out_valid_q || out_ready);

endmodule
